// File: rtl/hs_fifo.sv
// First-word fall-through elastic buffer on a valid/ready link.
// Both handshake outputs come straight from registered pointers, so there are no through-paths.
module hs_fifo #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         s_valid,
  input  logic [DATA_W-1:0]            s_data,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [DATA_W-1:0]            m_data,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     fill;
  logic              empty, full, push, pop;

  // Extra MSB on each pointer separates the full case from the empty case.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign s_ready = !full;
  assign m_valid = !empty;
  assign m_data  = mem[rd_ptr_q[AW-1:0]];

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign count = CW'(fill);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= s_data;
  end

endmodule

// File: tb/tb_hs_fifo.sv
// Directed bench for hs_fifo: reset, fill, drain, streaming wrap, full-with-pop, async reset.
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.
module tb_hs_fifo;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned DEPTH  = 4;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [2:0]        count;

  int n_cmp;
  int n_bad;

  hs_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .count    (count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (m_valid !== 1'b0 || count !== 3'd0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: m_valid=%b count=%0d, want 0/0", i, m_valid, count);
      end
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || count !== 3'd0) begin
        n_bad++;
        $display("FAIL reset_idle cyc%0d: m_valid=%b s_ready=%b count=%0d, want 0/1/0",
                 i, m_valid, s_ready, count);
      end
    end
  endtask

  task automatic test_fill();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = DATA_W'(i + 1);
      tick();
      n_cmp++;
      if (count !== 3'(i + 1) || m_valid !== 1'b1 || m_data !== 3'd1) begin
        n_bad++;
        $display("FAIL fill push%0d: count=%0d m_valid=%b m_data=%0d, want %0d/1/1",
                 i, count, m_valid, m_data, i + 1);
      end
    end
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_full_ready: s_ready=%b, want 0", s_ready);
    end
    s_data = 3'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (count !== 3'd4 || m_data !== 3'd1 || s_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL fill_reject cyc%0d: count=%0d m_data=%0d s_ready=%b, want 4/1/0",
                 i, count, m_data, s_ready);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_drain();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 3'(i + 1)) begin
        n_bad++;
        $display("FAIL drain_order pop%0d: m_valid=%b m_data=%0d, want 1/%0d",
                 i, m_valid, m_data, i + 1);
      end
      tick();
      if (i == 0) begin
        n_cmp++;
        if (s_ready !== 1'b1 || count !== 3'd3) begin
          n_bad++;
          $display("FAIL drain_ready: s_ready=%b count=%0d, want 1/3", s_ready, count);
        end
      end
    end
    n_cmp++;
    if (m_valid !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL drain_empty: m_valid=%b count=%0d, want 0/0", m_valid, count);
    end
    // Popping an empty buffer must not move the pointers.
    tick();
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || count !== 3'd0 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_pop_ignored: m_valid=%b count=%0d s_ready=%b, want 0/0/1",
               m_valid, count, s_ready);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_stream();
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = DATA_W'(i % 8);
      if (i > 0) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 3'((i - 1) % 8) || count !== 3'd1) begin
          n_bad++;
          $display("FAIL stream cyc%0d: m_valid=%b m_data=%0d count=%0d, want 1/%0d/1",
                   i, m_valid, m_data, count, (i - 1) % 8);
        end
      end
      tick();
    end
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 3'd3 || count !== 3'd1) begin
      n_bad++;
      $display("FAIL stream_tail: m_valid=%b m_data=%0d count=%0d, want 1/3/1",
               m_valid, m_data, count);
    end
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL stream_empty: m_valid=%b count=%0d, want 0/0", m_valid, count);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = DATA_W'(i + 1);
      tick();
    end
    n_cmp++;
    if (count !== 3'd4 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fullpop_setup: count=%0d s_ready=%b, want 4/0", count, s_ready);
    end
    s_data  = 3'd6;
    m_ready = 1'b1;
    tick();
    n_cmp++;
    if (count !== 3'd3 || m_data !== 3'd2 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fullpop_pop_only: count=%0d m_data=%0d s_ready=%b, want 3/2/1",
               count, m_data, s_ready);
    end
    m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (count !== 3'd4 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fullpop_push_next: count=%0d s_ready=%b, want 4/0", count, s_ready);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] exp;
      exp = (i == 3) ? 3'd6 : 3'(i + 2);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== exp) begin
        n_bad++;
        $display("FAIL fullpop_order pop%0d: m_valid=%b m_data=%0d, want 1/%0d",
                 i, m_valid, m_data, exp);
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 3'd1;
    tick();
    s_data  = 3'd2;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (count !== 3'd2 || m_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_setup: count=%0d m_valid=%b, want 2/1", count, m_valid);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || count !== 3'd0 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_async: m_valid=%b count=%0d s_ready=%b, want 0/0/1",
               m_valid, count, s_ready);
    end
    tick();
    sys_rst_n = 1'b1;
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL rstmid_released: m_valid=%b count=%0d, want 0/0", m_valid, count);
    end
    s_valid = 1'b1;
    s_data  = 3'd7;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 3'd7 || count !== 3'd1) begin
      n_bad++;
      $display("FAIL rstmid_push: m_valid=%b m_data=%0d count=%0d, want 1/7/1",
               m_valid, m_data, count);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL rstmid_no_stale: m_valid=%b count=%0d, want 0/0", m_valid, count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
